// File: rtl/led_matrix_pkg.sv
// Shared constants and types for the multiplexed 4x8 LED matrix driver.
package led_matrix_pkg;

   localparam int unsigned NUM_COLS      = 4;
   localparam int unsigned NUM_ROWS      = 8;
   localparam int unsigned FRAME_W       = 32;
   localparam int unsigned PWM_W         = 4;
   localparam int unsigned INTENSITY_MAX = 15;

   typedef logic [FRAME_W-1:0] frame_t;

   localparam frame_t FRAME_RESET = 32'h0000_0001;

endpackage

// File: rtl/led_matrix_pwm.sv
// Global brightness PWM: free-running 4-bit counter compared against a fixed level.
module led_matrix_pwm
   import led_matrix_pkg::*;
#(
   parameter int unsigned INTENSITY = 8
) (
   input  logic clk,
   input  logic rst_n,
   output logic pwm_on
);

   localparam logic [PWM_W-1:0] LEVEL = PWM_W'(INTENSITY);

   logic [PWM_W-1:0] p_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         p_q <= '0;
      end else begin
         p_q <= p_q + PWM_W'(1);
      end
   end

   // Full intensity bypasses the compare so the LED never blinks off.
   assign pwm_on = (INTENSITY == INTENSITY_MAX) || (p_q < LEVEL);

endmodule

// File: rtl/led_matrix_driver.sv
// Column-scanned 4x8 LED matrix driver with PWM brightness and a rotating marquee frame.
// Define LED_MATRIX_BLANK_EN to blank the rows during the first clock of every column slot.
module led_matrix_driver
   import led_matrix_pkg::*;
#(
   parameter int unsigned N1        = 16,
   parameter int unsigned N2        = 6000000,
   parameter int unsigned INTENSITY = 8
) (
   input  logic                CLK,
   input  logic                RST_N,
   output logic [NUM_ROWS-1:0] ROWS,
   output logic [NUM_COLS-1:0] COLS
);

   localparam int unsigned      AW        = $clog2(N2);
   localparam logic [AW-1:0]    ANIM_LAST = AW'(N2 - 1);

   logic [N1-1:0]       scan_q;
   logic [1:0]          col_q;
   logic [AW-1:0]       anim_q, anim_d;
   frame_t              frame_q, frame_d;
   logic [NUM_ROWS-1:0] rows_q, rows_d;
   logic [NUM_COLS-1:0] cols_q, cols_d;
   logic                pwm_on;

   led_matrix_pwm #(
      .INTENSITY (INTENSITY)
   ) u_pwm (
      .clk    (CLK),
      .rst_n  (RST_N),
      .pwm_on (pwm_on)
   );

   always_comb begin
      anim_d  = anim_q + AW'(1);
      frame_d = frame_q;
      if (anim_q == ANIM_LAST) begin
         anim_d  = '0;
         frame_d = {frame_q[FRAME_W-2:0], frame_q[FRAME_W-1]};
      end

      cols_d = ~(NUM_COLS'(1) << col_q);
      rows_d = ~(frame_q[NUM_ROWS*col_q +: NUM_ROWS] & {NUM_ROWS{pwm_on}});
`ifdef LED_MATRIX_BLANK_EN
      // Dark first clock of each slot hides the previous column's ghost.
      if (scan_q == '0) begin
         rows_d = '1;
      end
`endif
   end

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         scan_q  <= '0;
         col_q   <= '0;
         anim_q  <= '0;
         frame_q <= FRAME_RESET;
         rows_q  <= '1;
         cols_q  <= '1;
      end else begin
         scan_q  <= scan_q + N1'(1);
         if (&scan_q) begin
            col_q <= col_q + 2'd1;
         end
         anim_q  <= anim_d;
         frame_q <= frame_d;
         rows_q  <= rows_d;
         cols_q  <= cols_d;
      end
   end

   assign ROWS = rows_q;
   assign COLS = cols_q;

endmodule

// File: tb/tb_led_matrix_driver.sv
// Randomized-reset bench for led_matrix_driver at three brightness levels against an
// arithmetic model of scan position, marquee step and PWM phase.
module tb_led_matrix_driver;

   localparam int unsigned N1 = 3;
   localparam int unsigned N2 = 40;

   logic       clk;
   logic       rst_n;
   logic [7:0] rows_f, rows_4, rows_0;
   logic [3:0] cols_f, cols_4, cols_0;

   int n_checks = 0;
   int n_errors = 0;
   int edges    = 0;

   led_matrix_driver #(.N1(N1), .N2(N2), .INTENSITY(15)) dut (
      .CLK   (clk),
      .RST_N (rst_n),
      .ROWS  (rows_f),
      .COLS  (cols_f)
   );

   led_matrix_driver #(.N1(N1), .N2(N2), .INTENSITY(4)) dut_i4 (
      .CLK   (clk),
      .RST_N (rst_n),
      .ROWS  (rows_4),
      .COLS  (cols_4)
   );

   led_matrix_driver #(.N1(N1), .N2(N2), .INTENSITY(0)) dut_i0 (
      .CLK   (clk),
      .RST_N (rst_n),
      .ROWS  (rows_0),
      .COLS  (cols_0)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s at edge %0d: got %h expected %h", tag, edges, got, exp);
      end
   endtask

   // Output after edge e reflects the state reached after e-1 edges since reset release.
   function automatic logic [11:0] model(input int e, input int inten);
      int         s, col, step;
      logic [31:0] f;
      logic [7:0]  lit, rows;
      logic [3:0]  cols;
      bit          pwm;
      s    = e - 1;
      col  = (s / (1 << N1)) % 4;
      step = (s / N2) % 32;
      f    = 32'h1 << step;
      lit  = 8'((f >> (8 * col)) & 32'hFF);
      pwm  = (inten == 15) || ((s % 16) < inten);
      rows = pwm ? ~lit : 8'hFF;
`ifdef LED_MATRIX_BLANK_EN
      if ((s % (1 << N1)) == 0) rows = 8'hFF;
`endif
      cols = ~(4'b0001 << col);
      return {cols, rows};
   endfunction

   task automatic check_off(input string tag);
      check_eq({tag, "_rows"}, {24'h0, rows_f}, 32'hFF);
      check_eq({tag, "_cols"}, {28'h0, cols_f}, 32'hF);
      check_eq({tag, "_rows_i4"}, {24'h0, rows_4}, 32'hFF);
      check_eq({tag, "_rows_i0"}, {24'h0, rows_0}, 32'hFF);
   endtask

   task automatic run_cycles(input int n);
      logic [11:0] exp;
      for (int i = 0; i < n; i++) begin
         @(posedge clk);
         edges++;
         @(negedge clk);
         exp = model(edges, 15);
         check_eq("cols", {28'h0, cols_f}, {28'h0, exp[11:8]});
         check_eq("rows_i15", {24'h0, rows_f}, {24'h0, exp[7:0]});
         check_eq("one_cold", $countones(~cols_f), 1);
         exp = model(edges, 4);
         check_eq("rows_i4", {24'h0, rows_4}, {24'h0, exp[7:0]});
         check_eq("cols_i4", {28'h0, cols_4}, {28'h0, exp[11:8]});
         exp = model(edges, 0);
         check_eq("rows_i0", {24'h0, rows_0}, {24'h0, exp[7:0]});
      end
   endtask

   initial begin
      rst_n = 1'b0;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         check_off("reset");
      end
      rst_n = 1'b1;
      edges = 0;
      // Beyond 32 marquee steps so the lit LED wraps back to bit 0.
      run_cycles(32 * N2 + 60);

      for (int r = 0; r < 3; r++) begin
         run_cycles(int'($urandom_range(60, 140)));
         @(posedge clk);
         edges++;
         #($urandom_range(1, 3));
         rst_n = 1'b0;
         #1;
         check_off("async_reset");
         for (int i = 0; i < int'($urandom_range(1, 4)); i++) begin
            @(negedge clk);
            check_off("reset_hold");
         end
         @(negedge clk);
         rst_n = 1'b1;
         edges = 0;
         run_cycles(2 * N2 + 20);
      end

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

endmodule
